// File: rtl/debounce_pkg.sv
// Shared types and defaults for the three-channel switch debouncer.
// Imported by deb_chan and switch_debounce3.
package debounce_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } deb_state_t;

    localparam int DEF_STABLE_CYCLES = 16;
    localparam int DEF_CNT_W         = 16;

    // Bit positions of each switch within sw_in.
    localparam int SW_A = 2;
    localparam int SW_B = 1;
    localparam int SW_C = 0;

endpackage

// File: rtl/switch_debounce3_deb_chan.sv
// Single-bit debounce channel: two-flop synchroniser followed by an IDLE/COUNT
// stability FSM. upd pulses for one cycle together with each output update.
module deb_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic upd,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    deb_state_t       state;
    deb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dout_nxt;
    logic             fire;

    // din is asynchronous; only s2 is safe to use downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dout  <= 1'b0;
            upd   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dout  <= dout_nxt;
            upd   <= fire;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        fire      = 1'b0;
        unique case (state)
            IDLE: begin
                if (s2 != dout) begin
                    state_nxt = COUNT;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end
            COUNT: begin
                if (s2 == dout) begin
                    // Bounce back: discard the candidate and restart the window later.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    dout_nxt  = s2;
                    fire      = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == COUNT);

endmodule

// File: rtl/switch_debounce3.sv
// Three-switch debouncer feeding a/b/c, with a change strobe and settled flag.
// Define SWITCH_DEBOUNCE3_CHG_CNT_EN to add the 8-bit chg_count output.
module switch_debounce3
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       changed,
`ifdef SWITCH_DEBOUNCE3_CHG_CNT_EN
    output logic       settled,
    output logic [7:0] chg_count
`else
    output logic       settled
`endif
);

    logic [2:0] level;
    logic [2:0] upd;
    logic [2:0] busy;

    for (genvar i = 0; i < 3; i++) begin : g_chan
        deb_chan #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .din (sw_in[i]),
            .dout(level[i]),
            .upd (upd[i]),
            .busy(busy[i])
        );
    end

    assign a = level[SW_A];
    assign b = level[SW_B];
    assign c = level[SW_C];

    // Simultaneous updates merge into a single pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed <= 1'b0;
        end else begin
            changed <= |upd;
        end
    end

    assign settled = ~|busy;

`ifdef SWITCH_DEBOUNCE3_CHG_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_count <= 8'd0;
        end else if (changed) begin
            chg_count <= chg_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debounce3.sv
// Scoreboard bench for switch_debounce3 with STABLE_CYCLES=4: stimulus queues
// the expected a/b/c level and cycle of each changed pulse; a monitor checks them.
module tb_switch_debounce3;

    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 16;
    // Input applied after edge k: output at edge k+2+STABLE_CYCLES, changed at the next edge.
    localparam int CHG_LAT       = STABLE_CYCLES + 3;

    typedef struct {
        logic [2:0] abc;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] sw_in;
    logic       a;
    logic       b;
    logic       c;
    logic       changed;
    logic       settled;
`ifdef SWITCH_DEBOUNCE3_CHG_CNT_EN
    logic [7:0] chg_count;
    int         exp_cnt;
`endif

    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    exp_t mon_e;

    switch_debounce3 #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_in    (sw_in),
        .a        (a),
        .b        (b),
        .c        (c),
        .changed  (changed),
`ifdef SWITCH_DEBOUNCE3_CHG_CNT_EN
        .settled  (settled),
        .chg_count(chg_count)
`else
        .settled  (settled)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a new switch pattern that is expected to qualify.
    task automatic apply_ev(input logic [2:0] v);
        exp_t e;
        sw_in = v;
        e.abc = v;
        e.cyc = cyc + CHG_LAT;
        sb.push_back(e);
`ifdef SWITCH_DEBOUNCE3_CHG_CNT_EN
        exp_cnt = (exp_cnt + 1) % 256;
`endif
    endtask

    always @(negedge clk) begin
        if (changed === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_changed", 32'(changed), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("event_abc", 32'({a, b, c}), 32'(mon_e.abc));
                check("event_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
`ifdef SWITCH_DEBOUNCE3_CHG_CNT_EN
        exp_cnt  = 0;
`endif
        rst   = 1'b1;
        sw_in = 3'b111;
        step(3);
        check("rst_abc", 32'({a, b, c}), 32'd0);
        check("rst_settled", 32'(settled), 32'd1);
        check("rst_changed", 32'(changed), 32'd0);
`ifdef SWITCH_DEBOUNCE3_CHG_CNT_EN
        check("rst_chg_count", 32'(chg_count), 32'd0);
`endif
        // Release with all switches already high: all three requalify together.
        rst = 1'b0;
        apply_ev(3'b111);
        step(5);
        check("rel_abc_pre", 32'({a, b, c}), 32'd0);
        step(1);
        check("rel_abc_edge6", 32'({a, b, c}), 32'h7);
        step(6);

        apply_ev(3'b000);
        step(10);

        // Clean step on a with settled tracking.
        apply_ev(3'b100);
        step(2);
        check("step_settled_e2", 32'(settled), 32'd1);
        step(1);
        check("step_settled_e3", 32'(settled), 32'd0);
        step(2);
        check("step_settled_e5", 32'(settled), 32'd0);
        check("step_a_e5", 32'(a), 32'd0);
        step(1);
        check("step_settled_e6", 32'(settled), 32'd1);
        check("step_abc_e6", 32'({a, b, c}), 32'h4);
        check("step_changed_e6", 32'(changed), 32'd0);
        step(1);
        check("step_changed_e7", 32'(changed), 32'd1);
        step(1);
        check("step_changed_e8", 32'(changed), 32'd0);
        step(4);

        apply_ev(3'b000);
        step(10);

        // Bounce on b: each high phase is too short to qualify.
        sw_in = 3'b010;
        step(2);
        sw_in = 3'b000;
        step(2);
        sw_in = 3'b010;
        step(2);
        sw_in = 3'b000;
        step(2);
        check("bounce_b_low", 32'(b), 32'd0);
        apply_ev(3'b010);
        step(5);
        check("bounce_b_e5", 32'(b), 32'd0);
        step(1);
        check("bounce_b_e6", 32'(b), 32'd1);
        step(6);

        apply_ev(3'b000);
        step(10);

        // Simultaneous rise on b and c.
        apply_ev(3'b011);
        step(6);
        check("simul_abc_e6", 32'({a, b, c}), 32'h3);
        step(4);
`ifdef SWITCH_DEBOUNCE3_CHG_CNT_EN
        check("simul_chg_count", 32'(chg_count), 32'(exp_cnt));
`endif

        apply_ev(3'b000);
        step(10);

        // Reset in the middle of qualifying c.
        sw_in = 3'b001;
        step(4);
        rst = 1'b1;
        #1;
        check("midrst_c", 32'(c), 32'd0);
        check("midrst_settled", 32'(settled), 32'd1);
`ifdef SWITCH_DEBOUNCE3_CHG_CNT_EN
        check("midrst_chg_count", 32'(chg_count), 32'd0);
        exp_cnt = 0;
`endif
        step(2);
        rst = 1'b0;
        apply_ev(3'b001);
        step(5);
        check("midrst_c_e5", 32'(c), 32'd0);
        step(1);
        check("midrst_c_e6", 32'(c), 32'd1);
        step(6);

`ifdef SWITCH_DEBOUNCE3_CHG_CNT_EN
        // 256 qualified toggles of a bring chg_count back around to 0.
        sw_in = 3'b000;
        rst   = 1'b1;
        step(2);
        rst     = 1'b0;
        exp_cnt = 0;
        step(2);
        for (int i = 0; i < 256; i++) begin
            apply_ev({~sw_in[2], 2'b00});
            step(8);
            if (i == 127) check("wrap_mid", 32'(chg_count), 32'(exp_cnt));
        end
        check("wrap_zero", 32'(chg_count), 32'd0);
`endif

        step(4);
        check("pending_events", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
